// File: rtl/block_interleaver_pkg.sv
// Shared constants, bank-state type and the output-position to input-index map
// for the 8x16 bit block interleaver.
package block_interleaver_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 16;
  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic {
    Empty = 1'b0,
    Full  = 1'b1
  } bank_state_e;

  // Column-major read: position p = c*8 + r holds input index n = r*16 + c.
  function automatic logic [IdxW-1:0] pos_to_idx(input logic [IdxW-1:0] p);
    return {p[2:0], p[6:3]};
  endfunction

endpackage

// File: rtl/block_interleaver_if.sv
// Serial bit-stream handshake bundle: input side and interleaved output side.
interface block_interleaver_if;

  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_ready;
  logic out_first;
  logic out_last;

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_first,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_first,
    output out_last
  );

endinterface

// File: rtl/interleave_bank.sv
// One ping-pong storage bank: bit-addressed write port, read mux and EMPTY/FULL flag.
module interleave_bank
  import block_interleaver_pkg::*;
#(
  parameter int unsigned Bits = N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [IdxW-1:0]     wr_idx_i,
  input  logic                wr_bit_i,
  input  logic                set_full_i,
  input  logic                set_empty_i,
  input  logic [IdxW-1:0]     rd_idx_i,
  output logic                rd_bit_o,
  output bank_state_e         state_o
);

  logic [Bits-1:0] mem_q, mem_d;
  bank_state_e     state_q, state_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_bit_i;
    end
  end

  always_comb begin
    state_d = state_q;
    if (set_full_i) begin
      state_d = Full;
    end else if (set_empty_i) begin
      state_d = Empty;
    end
  end

  // Contents are not reset; only the flag decides whether data is meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= Empty;
    end else begin
      state_q <= state_d;
    end
  end

  assign rd_bit_o = mem_q[rd_idx_i];
  assign state_o  = state_q;

endmodule

// File: rtl/block_interleaver.sv
// 8x16 row-in / column-out bit interleaver with two ping-pong banks so a block can be
// filled while the previous one drains.
module block_interleaver #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  block_interleaver_if.slave   bus,
  output logic [6:0]           wr_count,
  output logic [15:0]          blocks_done
);

  import block_interleaver_pkg::*;

  localparam int unsigned Bits = ROWS * COLS;

  logic [IdxW-1:0] wr_count_q, wr_count_d;
  logic [IdxW-1:0] rd_count_q, rd_count_d;
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [15:0]     blocks_done_q, blocks_done_d;

  bank_state_e     bank_state [2];
  logic            bank_rd_bit [2];
  logic            bank_wr_en [2];
  logic            bank_set_full [2];
  logic            bank_set_empty [2];
  logic [IdxW-1:0] rd_idx;

  logic in_fire, out_fire, wr_wrap, rd_wrap;

  assign bus.in_ready  = (bank_state[wr_sel_q] == Empty);
  assign bus.out_valid = (bank_state[rd_sel_q] == Full);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign wr_wrap  = in_fire & (wr_count_q == IdxW'(N - 1));
  assign rd_wrap  = out_fire & (rd_count_q == IdxW'(N - 1));

  assign rd_idx        = pos_to_idx(rd_count_q);
  assign bus.out_bit   = bank_rd_bit[rd_sel_q];
  assign bus.out_first = bus.out_valid & (rd_count_q == '0);
  assign bus.out_last  = bus.out_valid & (rd_count_q == IdxW'(N - 1));

  // The write and read selects only ever point at the same bank when it is
  // EMPTY (no read) or FULL (no write), so the two sides never collide.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_wr_en[i]     = in_fire & (wr_sel_q == 1'(i));
      bank_set_full[i]  = wr_wrap & (wr_sel_q == 1'(i));
      bank_set_empty[i] = rd_wrap & (rd_sel_q == 1'(i));
    end
  end

  always_comb begin
    wr_count_d    = wr_count_q;
    rd_count_d    = rd_count_q;
    wr_sel_d      = wr_sel_q;
    rd_sel_d      = rd_sel_q;
    blocks_done_d = blocks_done_q;
    if (in_fire) begin
      wr_count_d = wr_count_q + 1'b1;
    end
    if (wr_wrap) begin
      wr_sel_d = ~wr_sel_q;
    end
    if (out_fire) begin
      rd_count_d = rd_count_q + 1'b1;
    end
    if (rd_wrap) begin
      rd_sel_d      = ~rd_sel_q;
      blocks_done_d = blocks_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    interleave_bank #(
      .Bits(Bits)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (bank_wr_en[g]),
      .wr_idx_i   (wr_count_q),
      .wr_bit_i   (bus.in_bit),
      .set_full_i (bank_set_full[g]),
      .set_empty_i(bank_set_empty[g]),
      .rd_idx_i   (rd_idx),
      .rd_bit_o   (bank_rd_bit[g]),
      .state_o    (bank_state[g])
    );
  end

  assign wr_count    = wr_count_q;
  assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_block_interleaver.sv
// Randomized self-checking bench for block_interleaver against a row/column matrix model.
module tb_block_interleaver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  wr_count;
  logic [15:0] blocks_done;

  block_interleaver_if bus ();

  block_interleaver dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .wr_count   (wr_count),
    .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit in_q[$];
  bit got_q[$];
  bit gfirst_q[$];
  bit glast_q[$];
  int cyc = 0;
  int last_in_cyc, first_out_cyc, last_out_cyc, in_stalls;
  int exp_blocks = 0;

  function automatic void clear_tracking();
    in_q.delete(); got_q.delete(); gfirst_q.delete(); glast_q.delete();
    last_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; in_stalls = 0;
  endfunction

  // Matrix model: bit n lands at row n/16, column n%16; read column by column.
  function automatic void interleave_model(input bit src[$], output bit dst[$]);
    bit blk [128];
    dst.delete();
    for (int b = 0; b < src.size() / 128; b++) begin
      for (int n = 0; n < 128; n++) begin
        int r = n / 16;
        int c = n % 16;
        blk[c * 8 + r] = src[b * 128 + n];
      end
      for (int p = 0; p < 128; p++) dst.push_back(blk[p]);
    end
  endfunction

  // Reference deinterleaver: write column by column, read row by row.
  function automatic void deinterleave_model(input bit src[$], output bit dst[$]);
    bit mat [8][16];
    dst.delete();
    for (int b = 0; b < src.size() / 128; b++) begin
      for (int p = 0; p < 128; p++) mat[p % 8][p / 8] = src[b * 128 + p];
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 16; c++) dst.push_back(mat[r][c]);
    end
  endfunction

  task automatic cycle(input bit ivld_en, input bit ordy);
    @(negedge clk);
    bus.in_valid  = ivld_en && (in_q.size() > 0);
    bus.in_bit    = (in_q.size() > 0) ? in_q[0] : 1'b0;
    bus.out_ready = ordy;
    #1;
    if (bus.in_valid && !bus.in_ready) in_stalls++;
    if (bus.in_valid && bus.in_ready) begin
      void'(in_q.pop_front());
      if (in_q.size() == 0) last_in_cyc = cyc;
    end
    if (bus.out_valid && ordy) begin
      got_q.push_back(bus.out_bit);
      gfirst_q.push_back(bus.out_first);
      glast_q.push_back(bus.out_last);
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      if (bus.out_last) exp_blocks++;
    end
    cyc++;
  endtask

  task automatic run_until(input int target, input int limit, input int vld_pct,
                           input int rdy_pct, output bit timed_out);
    int g = 0;
    while (got_q.size() < target && g < limit) begin
      cycle($urandom_range(99) < vld_pct, $urandom_range(99) < rdy_pct);
      g++;
    end
    timed_out = (got_q.size() < target);
  endtask

  task automatic count_mismatch(input bit a[$], input bit b[$], output int bad);
    bad = 0;
    for (int i = 0; i < b.size(); i++) if (i >= a.size() || a[i] !== b[i]) bad++;
  endtask

  task automatic apply_reset_and_check(input string tag);
    @(negedge clk);
    reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    exp_blocks = 0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_first !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.in_ready !== 1'b1 || wr_count !== 7'd0 || blocks_done !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b first=%b last=%b in_ready=%b wr_count=%0d done=%0d, need 0,0,0,1,0,0",
               tag, bus.out_valid, bus.out_first, bus.out_last, bus.in_ready, wr_count,
               blocks_done);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_tracking();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset_and_check("reset_state");
  endtask

  task automatic test_single_block();
    bit src[$], exp[$];
    bit to;
    int bad, nf, nl;
    clear_tracking();
    for (int n = 0; n < 128; n++) src.push_back(1'(n & 1));
    in_q = src;
    interleave_model(src, exp);
    run_until(128, 400, 100, 100, to);
    cycle(0, 1);
    count_mismatch(got_q, exp, bad);
    n_checks++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL single_data: got %0d bits with %0d wrong, need 128 with 0 wrong", got_q.size(), bad);
    end
    n_checks++;
    if (!to) begin
      logic [15:0] head = '0;
      for (int i = 0; i < 16; i++) head[15 - i] = got_q[i];
      if (head !== 16'h00FF) begin
        n_fail++;
        $display("FAIL single_head: got %h need 00ff", head);
      end
    end else begin
      n_fail++;
      $display("FAIL single_head: got timeout need 00ff");
    end
    nf = 0; nl = 0;
    for (int i = 0; i < gfirst_q.size(); i++) begin
      if (gfirst_q[i] !== (i == 0)) nf++;
      if (glast_q[i] !== (i == 127)) nl++;
    end
    n_checks++;
    if (to || nf != 0 || nl != 0) begin
      n_fail++;
      $display("FAIL single_flags: got %0d first / %0d last misplaced, need 0/0", nf, nl);
    end
    n_checks++;
    if (first_out_cyc - last_in_cyc != 1) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles need 1", first_out_cyc - last_in_cyc);
    end
    n_checks++;
    if (blocks_done !== 16'(exp_blocks) || exp_blocks != 1) begin
      n_fail++;
      $display("FAIL single_blocks_done: got %0d need 1", blocks_done);
    end
  endtask

  task automatic test_one_hot();
    bit src[$];
    bit to;
    int ones, pos;
    clear_tracking();
    for (int n = 0; n < 128; n++) src.push_back(n == 17);
    in_q = src;
    run_until(128, 400, 100, 100, to);
    ones = 0; pos = -1;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i]) begin ones++; pos = i; end
    n_checks++;
    if (to || ones != 1 || pos != 9) begin
      n_fail++;
      $display("FAIL one_hot: got %0d ones last at %0d, need 1 at 9", ones, pos);
    end
  endtask

  task automatic test_backpressure();
    bit src[$], exp[$];
    bit to, ref_bit;
    int bad, unstable;
    int base;
    clear_tracking();
    base = exp_blocks;
    for (int n = 0; n < 257; n++) src.push_back(1'($urandom_range(1)));
    in_q = src;
    repeat (300) cycle(1, 0);
    n_checks++;
    if (in_q.size() != 1 || bus.in_ready !== 1'b0 || got_q.size() != 0 ||
        bus.out_valid !== 1'b1 || wr_count !== 7'd0) begin
      n_fail++;
      $display("FAIL bp_full: got pending=%0d in_ready=%b out_valid=%b wr_count=%0d, need 1,0,1,0",
               in_q.size(), bus.in_ready, bus.out_valid, wr_count);
    end
    ref_bit = bus.out_bit;
    unstable = 0;
    repeat (16) begin
      cycle(1, 0);
      if (bus.out_bit !== ref_bit || bus.out_first !== 1'b1 || bus.out_last !== 1'b0) unstable++;
    end
    n_checks++;
    if (unstable != 0 || in_q.size() != 1) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles, pending=%0d, need 0 and 1", unstable, in_q.size());
    end
    in_q.delete();
    src.delete(256);
    interleave_model(src, exp);
    run_until(256, 600, 0, 100, to);
    cycle(0, 0);
    count_mismatch(got_q, exp, bad);
    n_checks++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d bits with %0d wrong, need 256 with 0 wrong", got_q.size(), bad);
    end
    n_checks++;
    if (blocks_done !== 16'(exp_blocks) || exp_blocks - base != 2) begin
      n_fail++;
      $display("FAIL bp_blocks_done: got %0d need %0d", blocks_done, base + 2);
    end
  endtask

  task automatic test_back_to_back();
    bit src[$], exp[$];
    bit to;
    int bad, base;
    clear_tracking();
    base = exp_blocks;
    for (int n = 0; n < 512; n++) src.push_back(1'($urandom_range(1)));
    in_q = src;
    interleave_model(src, exp);
    run_until(512, 800, 100, 100, to);
    cycle(0, 1);
    count_mismatch(got_q, exp, bad);
    n_checks++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL stream_data: got %0d bits with %0d wrong, need 512 with 0 wrong", got_q.size(), bad);
    end
    n_checks++;
    if (in_stalls != 0) begin
      n_fail++;
      $display("FAIL stream_in_ready: got %0d stall cycles need 0", in_stalls);
    end
    n_checks++;
    if (last_out_cyc - first_out_cyc != 511) begin
      n_fail++;
      $display("FAIL stream_gapless: got span %0d need 511", last_out_cyc - first_out_cyc);
    end
    n_checks++;
    if (blocks_done !== 16'(exp_blocks) || exp_blocks - base != 4) begin
      n_fail++;
      $display("FAIL stream_blocks_done: got %0d need %0d", blocks_done, base + 4);
    end
  endtask

  task automatic test_reset_mid();
    bit src[$], exp[$];
    bit to;
    int bad;
    clear_tracking();
    for (int n = 0; n < 60; n++) in_q.push_back(1'($urandom_range(1)));
    for (int g = 0; g < 200 && in_q.size() > 0; g++) cycle(1, 1);
    apply_reset_and_check("reset_after_60_in");
    for (int n = 0; n < 128; n++) in_q.push_back(1'($urandom_range(1)));
    run_until(30, 400, 100, 100, to);
    apply_reset_and_check("reset_after_30_out");
    for (int n = 0; n < 128; n++) src.push_back(1'($urandom_range(1)));
    in_q = src;
    interleave_model(src, exp);
    run_until(128, 400, 100, 100, to);
    cycle(0, 1);
    count_mismatch(got_q, exp, bad);
    n_checks++;
    if (to || bad != 0 || blocks_done !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_fresh_block: got %0d bits, %0d wrong, done=%0d, need 128, 0, 1",
               got_q.size(), bad, blocks_done);
    end
  endtask

  task automatic test_loopback();
    bit src[$], back[$];
    bit to;
    int bad, base;
    clear_tracking();
    base = exp_blocks;
    for (int n = 0; n < 1024; n++) src.push_back(1'($urandom_range(1)));
    in_q = src;
    run_until(1024, 6000, 80, 70, to);
    cycle(0, 0);
    deinterleave_model(got_q, back);
    count_mismatch(back, src, bad);
    n_checks++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL loopback: got %0d bits with %0d wrong, need 1024 with 0 wrong", back.size(), bad);
    end
    n_checks++;
    if (blocks_done !== 16'(exp_blocks) || exp_blocks - base != 8) begin
      n_fail++;
      $display("FAIL loopback_blocks_done: got %0d need %0d", blocks_done, base + 8);
    end
  endtask

  initial begin
    clear_tracking();
    test_reset();
    test_single_block();
    test_one_hot();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
